// File: rtl/pc_if.sv
// pc_if: fetch-side bundle of the program-counter unit.
// master = pipeline control driving the PC unit, slave = pc_unit itself.
interface pc_if #(
  parameter int WIDTH      = 32,
  parameter int HIST_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
);
  localparam int IDX_W = $clog2(HIST_DEPTH);

  logic                 stall;
  logic [1:0]           PCsrc;
  logic [WIDTH-1:0]     ImmOp;
  logic [WIDTH-1:0]     RegBase;
  logic [IDX_W-1:0]     hist_rd_idx;

  logic [WIDTH-1:0]     PC;
  logic                 PC_valid;
  logic [WIDTH-1:0]     inc_PC;
  logic                 misaligned;
  logic [CNT_WIDTH-1:0] instret;
  logic [WIDTH-1:0]     hist_rd_data;
  logic [IDX_W:0]       hist_count;

  modport master (
    output stall, PCsrc, ImmOp, RegBase, hist_rd_idx,
    input  PC, PC_valid, inc_PC, misaligned, instret, hist_rd_data, hist_count
  );

  modport slave (
    input  stall, PCsrc, ImmOp, RegBase, hist_rd_idx,
    output PC, PC_valid, inc_PC, misaligned, instret, hist_rd_data, hist_count
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: four-source next-PC selector with fetch stall, JALR, trap
// redirect, retired-instruction counter and a circular redirect history.
// Build option: define PC_MISALIGN_TRAP_EN to send misaligned branch/JALR
// targets to TRAP_VECTOR and pulse misaligned; otherwise such targets are
// force-aligned and misaligned stays 0.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int               HIST_DEPTH   = 4,
  parameter int               CNT_WIDTH    = 32
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);
  localparam int IDX_W = $clog2(HIST_DEPTH);

  logic [WIDTH-1:0]     pc_q;
  logic                 pc_valid_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [WIDTH-1:0]     hist_mem [HIST_DEPTH];
  logic [IDX_W-1:0]     wr_ptr;
  logic [IDX_W:0]       hist_cnt;

  logic [WIDTH-1:0]     inc_pc;
  logic [WIDTH-1:0]     br_tgt;
  logic [WIDTH-1:0]     jr_sum;
  logic [WIDTH-1:0]     raw_tgt;
  logic [WIDTH-1:0]     next_pc;
  logic                 mis_next;
  logic                 advance;
  logic [IDX_W-1:0]     rd_slot;

  assign advance = pc_valid_q && !bus.stall;

  // Next-PC selection; a misaligned target is either trapped or aligned depending on the build.
  always_comb begin
    inc_pc   = pc_q + WIDTH'(4);
    br_tgt   = pc_q + bus.ImmOp;
    jr_sum   = bus.RegBase + bus.ImmOp;
    raw_tgt  = (bus.PCsrc == 2'b01) ? br_tgt : {jr_sum[WIDTH-1:1], 1'b0};
    next_pc  = inc_pc;
    mis_next = 1'b0;
    case (bus.PCsrc)
      2'b00: next_pc = inc_pc;
      2'b11: next_pc = TRAP_VECTOR;
      default: begin
`ifdef PC_MISALIGN_TRAP_EN
        if (raw_tgt[1:0] != 2'b00) begin
          next_pc  = TRAP_VECTOR;
          mis_next = 1'b1;
        end else begin
          next_pc  = raw_tgt;
        end
`else
        next_pc = raw_tgt & ~WIDTH'(3);
`endif
      end
    endcase
  end

  // PC, valid flag, instret and redirect history; reset discards history contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      instret_q  <= '0;
      wr_ptr     <= '0;
      hist_cnt   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (!pc_valid_q) begin
      pc_valid_q <= 1'b1;
    end else if (!bus.stall) begin
      pc_q      <= next_pc;
      instret_q <= instret_q + CNT_WIDTH'(1);
      if (bus.PCsrc != 2'b00) begin
        hist_mem[wr_ptr] <= pc_q;
        wr_ptr           <= wr_ptr + IDX_W'(1);
        if (hist_cnt != (IDX_W+1)'(HIST_DEPTH)) hist_cnt <= hist_cnt + (IDX_W+1)'(1);
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic mis_q;

  // One-cycle misaligned pulse, only for accepted advances.
  always_ff @(posedge clk) begin
    if (rst || !advance) mis_q <= 1'b0;
    else                 mis_q <= mis_next;
  end

  assign bus.misaligned = mis_q;
`else
  logic unused_mis;
  assign unused_mis     = mis_next;
  assign bus.misaligned = 1'b0;
`endif

  // Index 0 is the most recent redirect; unwritten slots read as zero.
  always_comb begin
    rd_slot          = wr_ptr - IDX_W'(1) - bus.hist_rd_idx;
    bus.hist_rd_data = '0;
    if ({1'b0, bus.hist_rd_idx} < hist_cnt) bus.hist_rd_data = hist_mem[rd_slot];
  end

  assign bus.PC         = pc_q;
  assign bus.PC_valid   = pc_valid_q;
  assign bus.inc_PC     = inc_pc;
  assign bus.instret    = instret_q;
  assign bus.hist_count = hist_cnt;
endmodule
